// File: rtl/sobel_window_ctrl_pkg.sv
// Shared types and default geometry for the Sobel window sequencer.
// No logic here; latency and backpressure are owned by the modules that import it.
package sobel_window_ctrl_pkg;

    localparam int DEF_NBIT       = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int KERNEL_DIM     = 3;

    localparam int NUM_WIN_X = DEF_IMG_WIDTH - 2;
    localparam int NUM_WIN_Y = DEF_IMG_HEIGHT - 2;

    typedef logic [DEF_NBIT-1:0] pixel_t;
    typedef pixel_t [2:0][2:0]   window_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store (lb0 = previous row, lb1 = row before that) with a shared column address.
// Read is combinational, write lands on the clock edge; it never stalls, the caller gates wr_en.
module sobel_line_buffer #(
    parameter int NBIT      = 8,
    parameter int IMG_WIDTH = 640,
    parameter int AW        = $clog2(IMG_WIDTH)
) (
    input  logic            i_clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   addr,
    input  logic [NBIT-1:0] wr_dat,
    output logic [NBIT-1:0] rd0_dat,
    output logic [NBIT-1:0] rd1_dat
);

    logic [NBIT-1:0] lb0 [IMG_WIDTH];
    logic [NBIT-1:0] lb1 [IMG_WIDTH];

    // Contents are don't-care after reset, so the arrays carry no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            lb0[addr] <= wr_dat;
            lb1[addr] <= lb0[addr];
        end
    end

    assign rd0_dat = lb0[addr];
    assign rd1_dat = lb1[addr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Turns a raster pixel stream into 3x3 Sobel windows; window valid 1 cycle after the pixel, grad strobe 1 cycle after handshake.
// A held window (valid && !ready) freezes the window, the counters and the line buffers and drops o_pix_ready.
module sobel_window_ctrl
    import sobel_window_ctrl_pkg::*;
#(
    parameter int NBIT        = DEF_NBIT,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int KERNEL_SIZE = KERNEL_DIM,
    parameter int XW          = $clog2(IMG_WIDTH),
    parameter int YW          = $clog2(IMG_HEIGHT)
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst_n,
    input  logic                                               i_start,
    input  logic [NBIT-1:0]                                    i_pix,
    input  logic                                               i_pix_valid,
    output logic                                               o_pix_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0]  o_win,
    output logic                                               o_win_valid,
    input  logic                                               i_win_ready,
    output logic [XW-1:0]                                      o_win_x,
    output logic [YW-1:0]                                      o_win_y,
    output logic                                               o_grad_valid,
    output logic                                               o_busy,
    output logic                                               o_frame_done
);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] LAST_WX  = XW'(IMG_WIDTH - 2);
    localparam logic [YW-1:0] LAST_WY  = YW'(IMG_HEIGHT - 2);

    ctrl_state_e     state;
    logic [XW-1:0]   col;
    logic [YW-1:0]   row;
    logic            last_accepted;
    logic [NBIT-1:0] lb_rd0;
    logic [NBIT-1:0] lb_rd1;
    logic            pix_acc;
    logic            win_hs;
    logic            win_load;
    logic [NBIT-1:0] new_col [3];

    assign o_pix_ready = (state == RUN) && !last_accepted && (!o_win_valid || i_win_ready);
    assign pix_acc     = i_pix_valid && o_pix_ready;
    assign win_hs      = o_win_valid && i_win_ready;
    // Only windows fully inside one row span are real; col<2 would straddle a row wrap.
    assign win_load    = pix_acc && (row >= YW'(2)) && (col >= XW'(2));

    assign new_col[0] = lb_rd1;
    assign new_col[1] = lb_rd0;
    assign new_col[2] = i_pix;

    sobel_line_buffer #(
        .NBIT      (NBIT),
        .IMG_WIDTH (IMG_WIDTH),
        .AW        (XW)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .wr_en   (pix_acc),
        .addr    (col),
        .wr_dat  (i_pix),
        .rd0_dat (lb_rd0),
        .rd1_dat (lb_rd1)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            last_accepted <= 1'b0;
            o_win         <= '0;
            o_win_valid   <= 1'b0;
            o_win_x       <= '0;
            o_win_y       <= '0;
            o_grad_valid  <= 1'b0;
            o_frame_done  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_grad_valid <= win_hs;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state         <= RUN;
                        col           <= '0;
                        row           <= '0;
                        last_accepted <= 1'b0;
                        o_busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (pix_acc) begin
                        for (int r = 0; r < 3; r++) begin
                            o_win[r][0] <= o_win[r][1];
                            o_win[r][1] <= o_win[r][2];
                            o_win[r][2] <= new_col[r];
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                last_accepted <= 1'b1;
                            end else begin
                                row <= row + YW'(1);
                            end
                        end else begin
                            col <= col + XW'(1);
                        end
                    end
                    // A freshly loaded window takes priority over clearing the one being handed off.
                    if (win_load) begin
                        o_win_valid <= 1'b1;
                        o_win_x     <= col - XW'(1);
                        o_win_y     <= row - YW'(1);
                    end else if (win_hs) begin
                        o_win_valid <= 1'b0;
                    end
                    if (win_hs && (o_win_x == LAST_WX) && (o_win_y == LAST_WY)) begin
                        state        <= DONE;
                        o_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on an 8x6 frame: constant, ramps, stall, mid-frame reset, stray start.
module tb_sobel_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NW = (W - 2) * (H - 2);

    logic                   i_clk;
    logic                   i_rst_n;
    logic                   i_start;
    logic [7:0]             i_pix;
    logic                   i_pix_valid;
    logic                   o_pix_ready;
    logic [2:0][2:0][7:0]   o_win;
    logic                   o_win_valid;
    logic                   i_win_ready;
    logic [2:0]             o_win_x;
    logic [2:0]             o_win_y;
    logic                   o_grad_valid;
    logic                   o_busy;
    logic                   o_frame_done;

    int compared   = 0;
    int mismatched = 0;

    sobel_window_ctrl #(
        .NBIT       (8),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_pix        (i_pix),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .o_win        (o_win),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_win_x      (o_win_x),
        .o_win_y      (o_win_y),
        .o_grad_valid (o_grad_valid),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd100;
            1:       return 8'(10 * c);
            2:       return 8'(10 * r);
            default: return 8'(r * 16 + c * 3 + 7);
        endcase
    endfunction

    // Sobel taps as the conv stage applies them: gx = left - right, gy = top - bottom.
    function automatic int gx_of(input logic [2:0][2:0][7:0] w);
        return (int'(w[0][0]) + 2 * int'(w[1][0]) + int'(w[2][0]))
             - (int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2]));
    endfunction

    function automatic int gy_of(input logic [2:0][2:0][7:0] w);
        return (int'(w[0][0]) + 2 * int'(w[0][1]) + int'(w[0][2]))
             - (int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2]));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_win"},       o_win,        72'd0);
        chk({tag, "_win_valid"}, o_win_valid,  72'd0);
        chk({tag, "_win_x"},     o_win_x,      72'd0);
        chk({tag, "_win_y"},     o_win_y,      72'd0);
        chk({tag, "_grad"},      o_grad_valid, 72'd0);
        chk({tag, "_done"},      o_frame_done, 72'd0);
        chk({tag, "_busy"},      o_busy,       72'd0);
        chk({tag, "_pix_rdy"},   o_pix_ready,  72'd0);
    endtask

    task automatic start_frame();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 72'd1);
    endtask

    task automatic run_frame(input int mode, input int stall_at, input int start_at, input int abort_at);
        int pix_idx = 0;
        int k = 0;
        int stall_cnt = 0;
        int cyc = 0;
        int gx_exp;
        int gy_exp;
        logic prev_hs = 1'b0;
        logic hs;
        logic stalling;
        logic timed_out = 1'b0;
        logic [71:0] held_win = '0;
        logic [5:0]  held_xy = '0;
        logic [2:0][2:0][7:0] exp_win;
        case (mode)
            0:       begin gx_exp = 0;   gy_exp = 0;    end
            1:       begin gx_exp = -80; gy_exp = 0;    end
            2:       begin gx_exp = 0;   gy_exp = -80;  end
            default: begin gx_exp = -24; gy_exp = -128; end
        endcase
        while (!(abort_at >= 0 && pix_idx >= abort_at)) begin
            @(negedge i_clk);
            cyc++;
            if (cyc > 400) begin
                timed_out = 1'b1;
                break;
            end
            chk("grad_valid", o_grad_valid, prev_hs);
            chk("frame_done", o_frame_done, (prev_hs && k == NW));
            if (o_frame_done) break;
            stalling    = o_win_valid && (k == stall_at) && (stall_cnt < 5);
            if (stalling) stall_cnt++;
            i_win_ready = !stalling;
            i_start     = (pix_idx == start_at);
            i_pix_valid = (pix_idx < W * H);
            i_pix       = pat(mode, pix_idx / W, pix_idx % W);
            #1;
            if (stalling) begin
                if (stall_cnt == 1) begin
                    held_win = o_win;
                    held_xy  = {o_win_x, o_win_y};
                end else begin
                    chk("stall_win", o_win, held_win);
                    chk("stall_xy", {o_win_x, o_win_y}, held_xy);
                    chk("stall_valid", o_win_valid, 72'd1);
                end
                chk("stall_pix_rdy", o_pix_ready, 72'd0);
            end
            if (i_pix_valid && o_pix_ready) pix_idx++;
            hs = o_win_valid && i_win_ready;
            if (hs) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_win[r][c] = pat(mode, k / (W - 2) + r, k % (W - 2) + c);
                chk("win_x", o_win_x, k % (W - 2) + 1);
                chk("win_y", o_win_y, k / (W - 2) + 1);
                chk("win_dat", o_win, exp_win);
                chk("gx", gx_of(o_win), gx_exp);
                chk("gy", gy_of(o_win), gy_exp);
                k++;
            end
            prev_hs = hs;
        end
        if (abort_at < 0) begin
            i_pix_valid = 1'b0;
            i_start     = 1'b0;
            i_win_ready = 1'b1;
            chk("frame_timeout", timed_out, 72'd0);
            chk("win_count", k, NW);
            @(negedge i_clk);
            chk("done_single_pulse", o_frame_done, 72'd0);
            chk("busy_idle", o_busy, 72'd0);
            chk("pix_rdy_idle", o_pix_ready, 72'd0);
        end
    endtask

    initial begin
        i_rst_n     = 1'b1;
        i_start     = 1'b0;
        i_pix       = '0;
        i_pix_valid = 1'b0;
        i_win_ready = 1'b1;
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        start_frame();
        run_frame(0, -1, -1, -1);

        start_frame();
        run_frame(1, -1, -1, -1);

        start_frame();
        run_frame(2, -1, -1, -1);

        start_frame();
        run_frame(3, 3, -1, -1);

        // Abort a ramp frame after 20 pixels, then check a clean constant frame follows.
        start_frame();
        run_frame(1, -1, -1, 20);
        @(posedge i_clk);
        #2;
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        i_win_ready = 1'b1;
        chk("pre_reset_busy", o_busy, 72'd1);
        i_rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        start_frame();
        run_frame(0, -1, -1, -1);

        start_frame();
        run_frame(0, -1, 10, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
